// File: rtl/fp_norm_shift_ctrl_if.sv
// Bus between the normalization controller and its requester.
// The requester drives the request strobe and operands. The controller returns
// the handshake status and the registered normalization result.
interface fp_norm_shift_ctrl_if;
  logic        start;
  logic [24:0] mant_in;
  logic [7:0]  exp_in;
  logic        busy;
  logic        done;
  logic [22:0] mant_out;
  logic [7:0]  shift_count;
  logic [3:0]  alu_op;
  logic        adjust_en;
  logic        round_bit;
  logic        zero;
  logic        overflow;
  logic        underflow;

  modport master (
    output start, mant_in, exp_in,
    input  busy, done, mant_out, shift_count, alu_op, adjust_en,
           round_bit, zero, overflow, underflow
  );

  modport slave (
    input  start, mant_in, exp_in,
    output busy, done, mant_out, shift_count, alu_op, adjust_en,
           round_bit, zero, overflow, underflow
  );
endinterface

// File: rtl/fp_norm_shift_ctrl.sv
// Multi-cycle normalization controller for the single-precision datapath.
// It moves the leading one of a raw 25-bit significand into bit 23. It uses one
// right shift for a carry-out, or repeated single-bit left shifts. It then reports
// the exponent adjustment (magnitude, direction opcode, enable) for the exponent
// stage. The exponent itself is only used to flag overflow and underflow.
module fp_norm_shift_ctrl (
  input logic                  clk,
  input logic                  reset,
  fp_norm_shift_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    SHIFT_L = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;  // increase exponent
  localparam logic [3:0] OP_SUB = 4'b0011;  // decrease exponent

  state_t      state_reg;
  logic [24:0] mant_reg;
  logic [7:0]  exp_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [22:0] mant_out_reg;
  logic [7:0]  count_reg;
  logic [3:0]  alu_op_reg;
  logic        adjust_en_reg;
  logic        round_bit_reg;
  logic        zero_reg;
  logic        overflow_reg;
  logic        underflow_reg;

  // Controller FSM. All result outputs are registered here.
  // done is raised on the edge that enters DONE, so the results are already valid
  // while done is high. The results then hold until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mant_reg      <= '0;
      exp_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mant_out_reg  <= '0;
      count_reg     <= '0;
      alu_op_reg    <= OP_ADD;
      adjust_en_reg <= 1'b0;
      round_bit_reg <= 1'b0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mant_reg      <= bus.mant_in;
            exp_reg       <= bus.exp_in;
            count_reg     <= '0;
            alu_op_reg    <= OP_ADD;
            adjust_en_reg <= 1'b0;
            round_bit_reg <= 1'b0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            mant_out_reg  <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= CHECK;
          end
        end

        CHECK: begin
          if (mant_reg == 25'd0) begin
            // Nothing to normalize; the exponent passes through untouched.
            zero_reg      <= 1'b1;
            adjust_en_reg <= 1'b0;
            count_reg     <= '0;
            mant_out_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else if (mant_reg[24]) begin
            // Carry-out: a single right shift. The dropped LSB becomes round_bit.
            mant_reg      <= {1'b0, mant_reg[24:1]};
            mant_out_reg  <= mant_reg[23:1];
            round_bit_reg <= mant_reg[0];
            count_reg     <= 8'd1;
            alu_op_reg    <= OP_ADD;
            adjust_en_reg <= 1'b1;
            overflow_reg  <= (exp_reg >= 8'd254);
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else if (mant_reg[23]) begin
            adjust_en_reg <= 1'b0;
            count_reg     <= '0;
            alu_op_reg    <= OP_ADD;
            mant_out_reg  <= mant_reg[22:0];
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            // Leading one is below the hidden-bit position: start shifting left.
            mant_reg      <= {mant_reg[23:0], 1'b0};
            count_reg     <= 8'd1;
            alu_op_reg    <= OP_SUB;
            adjust_en_reg <= 1'b1;
            state_reg     <= SHIFT_L;
          end
        end

        SHIFT_L: begin
          if (mant_reg[23]) begin
            // Underflow is flagged when the decrease reaches zero or goes below it.
            mant_out_reg  <= mant_reg[22:0];
            underflow_reg <= (alu_op_reg == OP_SUB) && (count_reg >= exp_reg);
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            // The mantissa is nonzero, so the count stops at 23 at most.
            mant_reg  <= {mant_reg[23:0], 1'b0};
            count_reg <= count_reg + 8'd1;
          end
        end

        DONE: begin
          // done stays high for only one cycle. A start seen here is dropped.
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.mant_out    = mant_out_reg;
  assign bus.shift_count = count_reg;
  assign bus.alu_op      = alu_op_reg;
  assign bus.adjust_en   = adjust_en_reg;
  assign bus.round_bit   = round_bit_reg;
  assign bus.zero        = zero_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;

endmodule

// File: doc/fp_norm_shift_ctrl.md
# fp_norm_shift_ctrl

Multi-cycle normalization controller for the single-precision floating-point datapath. It takes a raw 25-bit mantissa from the significand adder together with the operand exponent and shifts the mantissa until the hidden bit sits in bit 23. It then reports the shift count, the direction as an ALU opcode, and an enable for the exponent increase/decrease stage. Its outputs drive that stage's shift-amount, opcode and enable inputs directly.

## Interface
- No parameters; widths are fixed for single precision: 8-bit exponent, 23-bit fraction.
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- mant_in  input  25  raw significand: bit 24 = carry-out, bit 23 = hidden bit, bits 22:0 = fraction.
- exp_in  input  8  biased exponent of the unnormalized result.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; all result outputs are valid and held until the next accepted start.
- mant_out  output  23  normalized fraction (hidden bit dropped).
- shift_count  output  8  magnitude of the exponent adjustment.
- alu_op  output  4  4'b0000 = increase exponent (add), 4'b0011 = decrease exponent (subtract).
- adjust_en  output  1  1 = the exponent stage must apply the adjustment; 0 = pass the exponent through.
- round_bit  output  1  bit shifted out on a right normalization, else 0.
- zero  output  1  mant_in was all zeros.
- overflow  output  1  the increase drives the exponent to 255.
- underflow  output  1  the decrease drives the exponent to 0 or below.

## Operation
- FSM states: IDLE, CHECK, SHIFT_L, DONE.
- **IDLE**
  - start=1: latch mant_in into a 25-bit working register and exp_in into an 8-bit register; clear the count, flags and round_bit; go to CHECK.
  - start=0: stay in IDLE.
- **CHECK**, evaluated in priority order:
  - mant==0: zero=1, adjust_en=0, shift_count=0 → DONE.
  - bit24=1: shift right by 1, round_bit=old bit0, shift_count=1, alu_op=0000, adjust_en=1, overflow=(exp>=254) → DONE.
  - bit23=1: already normalized; adjust_en=0, shift_count=0, alu_op=0000 → DONE.
  - Otherwise: shift left by 1, shift_count=1, alu_op=0011, adjust_en=1 → SHIFT_L.
- **SHIFT_L**
  - bit23=1 → DONE.
  - Otherwise: shift left by 1, shift_count+1, stay in SHIFT_L.
  - At most 23 left shifts are possible because mant is nonzero; the count never exceeds 23.
- **DONE**
  - done=1 for one cycle.
  - mant_out = working register bits 22:0.
  - underflow = (alu_op==0011) && (shift_count >= exp).
  - → IDLE.
- start is ignored while busy; there is no queueing.
- The exponent itself is never modified here; only the adjustment is reported.
- Result outputs (mant_out, shift_count, alu_op, adjust_en, round_bit, zero, overflow, underflow) are registered.
  - They update in CHECK/SHIFT_L/DONE.
  - They hold their values from DONE until the next accepted start.

## Timing
- Reset values: state=IDLE; busy, done, mant_out, shift_count, round_bit, zero, overflow, underflow, adjust_en all 0; alu_op=4'b0000.
- start sampled at edge T → busy=1 from T+1.
- Latency: done pulses in cycle T+2+k, where k = number of left shifts (k=0 for the zero, right-shift and already-normalized cases).
  - Best case: 2 cycles.
  - Worst case (mant_in=25'h1): 25 cycles.
- busy drops in the same cycle done rises.
- Back-to-back operation: start in the DONE cycle is ignored. start in the cycle after DONE (state is IDLE) is accepted, so the minimum issue interval is 3 cycles.
- reset asserted in any state returns the block to IDLE on that edge with all outputs at reset values; the in-flight operation is discarded and no done is issued.
- reset and start asserted in the same cycle: reset wins and start is dropped.

## Test plan
- Reset mid-operation: mant_in=25'h000001, start, then reset after 5 cycles → outputs return to 0, no done pulse; a following start with mant_in=25'h0800000 → done 2 cycles later.
- Carry out: mant_in=25'h1000001, exp_in=8'd100, start → done at T+2, mant_out=23'h000000, shift_count=1, alu_op=0000, adjust_en=1, round_bit=1, overflow=0; repeat with exp_in=8'd254 → overflow=1.
- Left normalize: mant_in=25'h0100000 (bit 20 set), exp_in=8'd10 → done at T+5, shift_count=3, alu_op=0011, adjust_en=1, mant_out=0, underflow=0; repeat with exp_in=8'd3 → underflow=1.
- Already normalized or zero: mant_in=25'h0C00000 → done at T+2, adjust_en=0, shift_count=0, mant_out=23'h400000; mant_in=0 → zero=1, adjust_en=0.
- Worst case plus ignored start: mant_in=25'h0000001 → done at T+25, shift_count=23, mant_out=0; a start pulse mid-operation is ignored, and the outputs stay stable until the next accepted start.
